rm_scheduler: RTL and testbench
===============================

# rm_scheduler

Sequencer that shares the single reconfigurable partition (RP) of the DPR top level between NUM_REQ requesters. Each request names an operator RM (ADD, COMP, DEC, DIV, INC, MOD, MUL, MUX2x1, SHL, SHR, SUB) plus operands. The scheduler arbitrates round-robin and triggers a partial reconfiguration only when the requested RM differs from the loaded one. It then drives the RP, captures the result and returns it to the winning requester.

## Interface
- DATAWIDTH, 2, operand/result width (matches RM DATAWIDTH)
- NUM_REQ, 4, number of requesters (2..8)
- RP_LATENCY, 1, cycles from RP inputs valid to result sampled (1..15)
- TIMEOUT, 1024, max cycles to wait for rm_load_done
- clk_in  in  1  single clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_op  in  4*NUM_REQ  opcode, requester i at [4i+3:4i]
- req_a, req_b  in  DATAWIDTH*NUM_REQ  operands, requester i at [DATAWIDTH*i +: DATAWIDTH]
- req_sel  in  NUM_REQ  MUX2x1 select per requester
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- rsp_valid  out  NUM_REQ  response valid, one-hot to granted requester
- rsp_ready  in  NUM_REQ  response accept
- rsp_data  out  DATAWIDTH  result
- rsp_flags  out  3  {gt,lt,eq}, COMP only, else 0
- rsp_err  out  1  illegal opcode or load timeout
- rm_load_req  out  1  one-cycle reconfiguration trigger
- rm_load_id  out  4  RM to load (= opcode)
- rm_load_done  in  1  reconfiguration complete pulse
- rp_decouple  out  1  RP isolation, high whenever no valid RM loaded
- rp_a, rp_b  out  DATAWIDTH  RP operands; rp_sel out 1 MUX select
- rp_result  in  DATAWIDTH; rp_gt, rp_lt, rp_eq  in  1  RP outputs
- loaded_valid  out  1; loaded_id  out  4; busy  out  1  (state != IDLE)

## Operation
- Opcodes: 0 ADD, 1 COMP, 2 DEC, 3 DIV, 4 INC, 5 MOD, 6 MUL, 7 MUX2x1, 8 SHL, 9 SHR, 10 SUB; 11-15 illegal.
- FSM states: IDLE, LOAD, EXEC, RESP.
- IDLE: grant is the lowest index ≥ rr_ptr (wrapping) with req_valid set. req_ready[grant] pulses; op, operands and sel are latched.
  - Illegal op -> RESP with rsp_err=1, rsp_data=0.
  - loaded_valid && loaded_id==op -> EXEC (hit).
  - Otherwise -> LOAD (miss).
- LOAD: entry cycle pulses rm_load_req with rm_load_id=op. loaded_valid is cleared, which raises rp_decouple. A wait counter starts at 0.
  - rm_load_done -> loaded_id=op, loaded_valid=1, go to EXEC.
  - Counter reaches TIMEOUT-1 without done -> RESP, rsp_err=1, rsp_data=0, loaded_valid stays 0.
  - Done and timeout in the same cycle: done wins.
- EXEC: rp_a/rp_b/rp_sel are driven from latched values and held for RP_LATENCY cycles. In the last EXEC cycle rp_result and the flags are registered; the flags are masked to 0 unless op=COMP. Next state is RESP.
- RESP: rsp_valid[grant] is held until rsp_ready[grant]. On that handshake cycle: rr_ptr=(grant+1) mod NUM_REQ, rsp_* cleared, go to IDLE.
- rp_a/rp_b/rp_sel are 0 outside EXEC.
- rm_load_done outside LOAD is ignored.
- req_valid may drop before grant; no request is queued.
- Requester must hold payload until its req_ready pulse.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0
  - rm_load_req=0, rm_load_id=0
  - rp_decouple=1, rp_a=rp_b=0, rp_sel=0
  - loaded_valid=0, loaded_id=0, busy=0, rr_ptr=0, state=IDLE
- Accept in cycle T (req_ready high). Hit: EXEC cycles T+1..T+RP_LATENCY, rsp_valid from T+RP_LATENCY+1.
- Miss: rm_load_req in T+1; done sampled in cycle D; EXEC from D+1; rsp_valid from D+RP_LATENCY+1.
- Earliest re-accept is the cycle after the rsp handshake; no IDLE bubble beyond that.
- Timeout: rsp_valid asserts TIMEOUT cycles after the rm_load_req cycle.
- Reset mid-operation (any state): immediate return to reset values. The in-flight request is dropped and loaded_valid=0, so the next request reloads its RM.

## Test plan
- Reset, then req0 op=0 a=1 b=2 -> rm_load_req id=0; done 5 cycles later; rsp_valid[0] with rsp_data=3, rsp_err=0, loaded_id=0.
- Second req0 op=0 a=3 b=3 -> no rm_load_req; rsp_data=2 (wrap) at accept+RP_LATENCY+1; rp_decouple stays 0.
- req0..req3 all valid, op=10 -> grants in order 0,1,2,3,0; only one rm_load_req total; rr_ptr wraps.
- req1 op=1 a=2 b=1 after ADD loaded -> reload id=1; rsp_flags=3'b100; req1 op=12 -> rsp_err=1, no load.
- Miss with rm_load_done withheld -> rsp_err=1 exactly TIMEOUT cycles after the req pulse; rp_decouple=1; next op=0 request reloads.
- rst_in low during LOAD, and done pulsed while idle -> all outputs at reset values; stray done ignored; loaded_valid=0.

Source files
------------

// File: rtl/rm_scheduler.sv
// rm_scheduler
// Shares one reconfigurable partition (RP) between NUM_REQ requesters.
// A round-robin arbiter picks one request, a partial reconfiguration is
// requested only when the wanted RM is not already loaded, the RP is then
// driven for RP_LATENCY cycles and its registered result is returned to the
// winning requester.
//
// Ports:
//   clk_in, rst_in            clock (rising edge), async active-low reset
//   req_valid/op/a/b/sel      per-requester request and payload
//   req_ready                 one-cycle, one-hot accept pulse
//   rsp_valid/ready           one-hot response handshake to the grantee
//   rsp_data/flags/err        result, {gt,lt,eq} for COMP, error flag
//   rm_load_req/id/done       reconfiguration trigger, RM id, completion
//   rp_decouple               RP isolation while no valid RM is loaded
//   rp_a/rp_b/rp_sel          RP operands (zero outside EXEC)
//   rp_result/gt/lt/eq        RP outputs
//   loaded_valid/id, busy     loaded RM status, FSM not idle
//
// Handshake: a request is taken in the cycle req_ready[i] is high (payload
// must be stable until then); a response completes in the cycle
// rsp_valid[i] && rsp_ready[i] are both high.
module rm_scheduler #(
    parameter int DATAWIDTH  = 2,
    parameter int NUM_REQ    = 4,
    parameter int RP_LATENCY = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [4*NUM_REQ-1:0]         req_op,
    input  logic [DATAWIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATAWIDTH*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_sel,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [DATAWIDTH-1:0]         rsp_data,
    output logic [2:0]                   rsp_flags,
    output logic                         rsp_err,
    output logic                         rm_load_req,
    output logic [3:0]                   rm_load_id,
    input  logic                         rm_load_done,
    output logic                         rp_decouple,
    output logic [DATAWIDTH-1:0]         rp_a,
    output logic [DATAWIDTH-1:0]         rp_b,
    output logic                         rp_sel,
    input  logic [DATAWIDTH-1:0]         rp_result,
    input  logic                         rp_gt,
    input  logic                         rp_lt,
    input  logic                         rp_eq,
    output logic                         loaded_valid,
    output logic [3:0]                   loaded_id,
    output logic                         busy
);

    localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW_T = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // One counter serves both the load wait and the EXEC hold time.
    localparam int CW   = (CW_T > 4) ? CW_T : 4;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(RP_LATENCY - 1);
    localparam logic [3:0]    OP_COMP  = 4'd1;
    localparam logic [3:0]    OP_MAX   = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         r_grant;
    logic [3:0]            r_op;
    logic [DATAWIDTH-1:0]  r_a;
    logic [DATAWIDTH-1:0]  r_b;
    logic                  r_sel;
    logic [CW-1:0]         r_cnt;
    logic                  r_loaded_valid;
    logic [3:0]            r_loaded_id;
    logic [DATAWIDTH-1:0]  r_rsp_data;
    logic [2:0]            r_rsp_flags;
    logic                  r_rsp_err;

    logic                  w_found;
    logic [GW-1:0]         w_grant;
    int                    w_idx;
    logic [3:0]            w_op_in;
    logic                  w_illegal;
    logic                  w_hit;

    // Round-robin search: first valid requester at or after r_rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = GW'(w_idx);
            end
        end
    end

    assign w_op_in   = req_op[4*int'(w_grant) +: 4];
    assign w_illegal = (w_op_in > OP_MAX);
    assign w_hit     = r_loaded_valid && (r_loaded_id == w_op_in);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_grant] = 1'b1;
                    if (w_illegal)  w_next = S_RESP;
                    else if (w_hit) w_next = S_EXEC;
                    else            w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // Completion beats the timeout when both land together.
                if (rm_load_done)          w_next = S_EXEC;
                else if (r_cnt == TO_LAST) w_next = S_RESP;
            end
            S_EXEC: begin
                if (r_cnt == LAT_LAST) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_grant] = 1'b1;
                if (rsp_ready[r_grant]) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_sel          <= 1'b0;
            r_cnt          <= '0;
            r_loaded_valid <= 1'b0;
            r_loaded_id    <= '0;
            r_rsp_data     <= '0;
            r_rsp_flags    <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_grant;
                        r_op    <= w_op_in;
                        r_a     <= req_a[DATAWIDTH*int'(w_grant) +: DATAWIDTH];
                        r_b     <= req_b[DATAWIDTH*int'(w_grant) +: DATAWIDTH];
                        r_sel   <= req_sel[w_grant];
                        r_cnt   <= '0;
                        if (w_illegal) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                        end else if (!w_hit) begin
                            // The RP contents become undefined as soon as
                            // a reload starts, so isolate it right away.
                            r_loaded_valid <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (rm_load_done) begin
                        r_loaded_valid <= 1'b1;
                        r_loaded_id    <= r_op;
                        r_cnt          <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == LAT_LAST) begin
                        r_rsp_data  <= rp_result;
                        r_rsp_flags <= (r_op == OP_COMP) ? {rp_gt, rp_lt, rp_eq} : 3'b000;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_grant]) begin
                        r_rr_ptr    <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_flags <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rm_load_req  = (r_state == S_LOAD) && (r_cnt == '0);
    assign rm_load_id   = (r_state == S_LOAD) ? r_op : 4'd0;
    assign rp_decouple  = ~r_loaded_valid;
    assign rp_a         = (r_state == S_EXEC) ? r_a : '0;
    assign rp_b         = (r_state == S_EXEC) ? r_b : '0;
    assign rp_sel       = (r_state == S_EXEC) ? r_sel : 1'b0;
    assign rsp_data     = r_rsp_data;
    assign rsp_flags    = r_rsp_flags;
    assign rsp_err      = r_rsp_err;
    assign loaded_valid = r_loaded_valid;
    assign loaded_id    = r_loaded_id;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_rm_scheduler.sv
// Directed bench for rm_scheduler (DATAWIDTH=2, NUM_REQ=4, RP_LATENCY=1,
// TIMEOUT=1024). A behavioural RP computes results from rp_a/rp_b/rp_sel for
// the RM the bench last reported as loaded.
module tb_rm_scheduler;

    localparam int DW  = 2;
    localparam int NR  = 4;
    localparam int LAT = 1;
    localparam int TO  = 1024;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [NR-1:0]   req_valid;
    logic [4*NR-1:0] req_op;
    logic [DW*NR-1:0] req_a;
    logic [DW*NR-1:0] req_b;
    logic [NR-1:0]   req_sel;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [2:0]      rsp_flags;
    logic            rsp_err;
    logic            rm_load_req;
    logic [3:0]      rm_load_id;
    logic            rm_load_done;
    logic            rp_decouple;
    logic [DW-1:0]   rp_a;
    logic [DW-1:0]   rp_b;
    logic            rp_sel;
    logic [DW-1:0]   rp_result;
    logic            rp_gt;
    logic            rp_lt;
    logic            rp_eq;
    logic            loaded_valid;
    logic [3:0]      loaded_id;
    logic            busy;

    rm_scheduler #(.DATAWIDTH(DW), .NUM_REQ(NR), .RP_LATENCY(LAT), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .rm_load_req(rm_load_req), .rm_load_id(rm_load_id), .rm_load_done(rm_load_done),
        .rp_decouple(rp_decouple), .rp_a(rp_a), .rp_b(rp_b), .rp_sel(rp_sel),
        .rp_result(rp_result), .rp_gt(rp_gt), .rp_lt(rp_lt), .rp_eq(rp_eq),
        .loaded_valid(loaded_valid), .loaded_id(loaded_id), .busy(busy)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk_in = ~clk_in;

    int cyc_n = 0;
    always @(posedge clk_in) cyc_n <= cyc_n + 1;

    // ---------------- behavioural RP ----------------
    logic [3:0] tb_rm = 4'd0;
    always_comb begin
        rp_result = '0;
        rp_gt     = 1'b0;
        rp_lt     = 1'b0;
        rp_eq     = 1'b0;
        if (!rp_decouple) begin
            rp_gt = (rp_a > rp_b);
            rp_lt = (rp_a < rp_b);
            rp_eq = (rp_a == rp_b);
            case (tb_rm)
                4'd0:    rp_result = rp_a + rp_b;
                4'd1:    rp_result = 2'd0;
                4'd2:    rp_result = rp_a - 2'd1;
                4'd3:    rp_result = (rp_b == 2'd0) ? 2'd0 : rp_a / rp_b;
                4'd4:    rp_result = rp_a + 2'd1;
                4'd5:    rp_result = (rp_b == 2'd0) ? rp_a : rp_a % rp_b;
                4'd6:    rp_result = rp_a * rp_b;
                4'd7:    rp_result = rp_sel ? rp_b : rp_a;
                4'd8:    rp_result = rp_a << 1;
                4'd9:    rp_result = rp_a >> 1;
                4'd10:   rp_result = rp_a - rp_b;
                default: rp_result = 2'd0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    int         g_acc, g_grant, g_load_cnt, g_load_cyc, g_rsp_cyc, g_hs;
    logic [3:0] g_load_id;
    logic [1:0] g_data;
    logic [2:0] g_flags;
    logic       g_err, g_dec_seen, g_dec_at_rsp, g_lv_at_rsp;

    task automatic set_req(input int idx, input logic [3:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic sel);
        req_op[4*idx +: 4]  = op;
        req_a[DW*idx +: DW] = a;
        req_b[DW*idx +: DW] = b;
        req_sel[idx]        = sel;
    endtask

    task automatic reset_dut();
        rst_in       = 1'b0;
        req_valid    = '0;
        rsp_ready    = '0;
        rm_load_done = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    // Waits for an accept, plays the loader (done dly cycles after the
    // rm_load_req cycle, dly<0 withholds it), then completes the response
    // one cycle after rsp_valid rises. Entered and left at posedge+1.
    task automatic serve(input int dly, input logic drop);
        bit found;
        bit got;
        int done_at;
        found        = 0;
        got          = 0;
        done_at      = -1;
        g_load_cnt   = 0;
        g_load_id    = 4'd0;
        g_load_cyc   = -1;
        g_dec_seen   = 1'b0;
        for (int w = 0; w < 50 && !found; w++) begin
            @(negedge clk_in);
            if (req_ready != '0) begin
                found = 1;
                g_acc = cyc_n;
                for (int i = 0; i < NR; i++) if (req_ready[i]) g_grant = i;
                chk("req_ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
            end else begin
                @(posedge clk_in); #1;
            end
        end
        if (!found) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk_in); #1;
        if (drop) req_valid[g_grant] = 1'b0;
        for (int w = 0; w < 3000 && !got; w++) begin
            @(negedge clk_in);
            g_dec_seen = g_dec_seen | rp_decouple;
            if (rm_load_req) begin
                g_load_cnt++;
                g_load_id  = rm_load_id;
                g_load_cyc = cyc_n;
                if (dly >= 0) done_at = cyc_n + dly;
            end
            if (rsp_valid != '0) begin
                got          = 1;
                g_rsp_cyc    = cyc_n;
                g_data       = rsp_data;
                g_flags      = rsp_flags;
                g_err        = rsp_err;
                g_dec_at_rsp = rp_decouple;
                g_lv_at_rsp  = loaded_valid;
                chk("rsp_onehot", {28'd0, rsp_valid}, 32'd1 << g_grant);
            end else begin
                @(posedge clk_in); #1;
                rm_load_done = (done_at >= 0) && (cyc_n == done_at);
                if (rm_load_done) tb_rm = g_load_id;
            end
        end
        rm_load_done = 1'b0;
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("rsp_hold", {28'd0, rsp_valid}, 32'd1 << g_grant);
        rsp_ready[g_grant] = 1'b1;
        g_hs = cyc_n;
        @(posedge clk_in); #1;
        rsp_ready = '0;
        chk("rsp_cleared", {22'd0, rsp_valid, rsp_data, rsp_flags, rsp_err}, 32'd0);
        chk("idle_after_hs", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int         idx;
        logic [3:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic       sel;
        int         dly;
        logic [1:0] e_data;
        logic [2:0] e_flags;
        logic       e_err;
        int         e_loads;
        int         e_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_rsp"}, {18'd0, req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err}, 32'd0);
        chk({tag, "_load"}, {27'd0, rm_load_req, rm_load_id}, 32'd0);
        chk({tag, "_rp"}, {26'd0, rp_decouple, rp_a, rp_b, rp_sel}, 32'h20);
        chk({tag, "_status"}, {26'd0, loaded_valid, loaded_id, busy}, 32'd0);
    endtask

    initial begin
        int         loads_total;
        int         prev_hs;
        bit         found;
        logic [1:0] exp_d;

        // latency: miss = dly + 3, hit = 2, illegal = 1 (RP_LATENCY = 1)
        vecs[0]  = '{0, 4'd0,  2'd1, 2'd2, 1'b0, 5, 2'd3, 3'b000, 1'b0, 1, 8};
        vecs[1]  = '{0, 4'd0,  2'd3, 2'd3, 1'b0, 1, 2'd2, 3'b000, 1'b0, 0, 2};
        vecs[2]  = '{1, 4'd1,  2'd2, 2'd1, 1'b0, 2, 2'd0, 3'b100, 1'b0, 1, 5};
        vecs[3]  = '{1, 4'd12, 2'd2, 2'd1, 1'b0, 1, 2'd0, 3'b000, 1'b1, 0, 1};
        vecs[4]  = '{2, 4'd1,  2'd1, 2'd3, 1'b0, 1, 2'd0, 3'b010, 1'b0, 0, 2};
        vecs[5]  = '{3, 4'd1,  2'd2, 2'd2, 1'b0, 1, 2'd0, 3'b001, 1'b0, 0, 2};
        vecs[6]  = '{0, 4'd7,  2'd1, 2'd2, 1'b1, 1, 2'd2, 3'b000, 1'b0, 1, 4};
        vecs[7]  = '{2, 4'd6,  2'd3, 2'd3, 1'b0, 1, 2'd1, 3'b000, 1'b0, 1, 4};
        vecs[8]  = '{1, 4'd9,  2'd3, 2'd0, 1'b0, 3, 2'd1, 3'b000, 1'b0, 1, 6};
        vecs[9]  = '{1, 4'd3,  2'd3, 2'd2, 1'b0, 1, 2'd1, 3'b000, 1'b0, 1, 4};
        vecs[10] = '{0, 4'd13, 2'd1, 2'd1, 1'b0, 1, 2'd0, 3'b000, 1'b1, 0, 1};
        vecs[11] = '{0, 4'd3,  2'd2, 2'd2, 1'b0, 1, 2'd1, 3'b000, 1'b0, 0, 2};

        req_op  = '0;
        req_a   = '0;
        req_b   = '0;
        req_sel = '0;

        // ---- reset values ----
        rst_in       = 1'b0;
        req_valid    = '0;
        rsp_ready    = '0;
        rm_load_done = 1'b0;
        @(negedge clk_in);
        check_reset_values("reset");
        reset_dut();

        // ---- table-driven single requests ----
        for (int e = 0; e < 12; e++) begin
            set_req(vecs[e].idx, vecs[e].op, vecs[e].a, vecs[e].b, vecs[e].sel);
            req_valid[vecs[e].idx] = 1'b1;
            serve(vecs[e].dly, 1'b1);
            chk($sformatf("v%0d_grant", e), g_grant, vecs[e].idx);
            chk($sformatf("v%0d_data", e), {30'd0, g_data}, {30'd0, vecs[e].e_data});
            chk($sformatf("v%0d_flags", e), {29'd0, g_flags}, {29'd0, vecs[e].e_flags});
            chk($sformatf("v%0d_err", e), {31'd0, g_err}, {31'd0, vecs[e].e_err});
            chk($sformatf("v%0d_loads", e), g_load_cnt, vecs[e].e_loads);
            chk($sformatf("v%0d_latency", e), g_rsp_cyc - g_acc, vecs[e].e_lat);
            if (vecs[e].e_loads == 1)
                chk($sformatf("v%0d_load_id", e), {28'd0, g_load_id}, {28'd0, vecs[e].op});
            if (vecs[e].e_loads == 0 && !vecs[e].e_err)
                chk($sformatf("v%0d_hit_coupled", e), {31'd0, g_dec_seen}, 32'd0);
            if (!vecs[e].e_err)
                chk($sformatf("v%0d_loaded", e), {27'd0, loaded_valid, loaded_id},
                    {27'd0, 1'b1, vecs[e].op});
        end

        // ---- round robin: all four requesters hold SUB requests ----
        reset_dut();
        for (int i = 0; i < NR; i++) set_req(i, 4'd10, 2'd3, 2'(i), 1'b0);
        req_valid   = '1;
        loads_total = 0;
        prev_hs     = 0;
        for (int n = 0; n < 5; n++) begin
            serve(1, 1'b0);
            chk($sformatf("rr%0d_grant", n), g_grant, n % NR);
            exp_d = 2'(3 - (n % NR));
            chk($sformatf("rr%0d_data", n), {30'd0, g_data}, {30'd0, exp_d});
            loads_total += g_load_cnt;
            if (n > 0) chk($sformatf("rr%0d_no_bubble", n), g_acc, prev_hs + 1);
            prev_hs = g_hs;
        end
        req_valid = '0;
        chk("rr_single_load", loads_total, 1);

        // ---- load timeout, then the same op reloads ----
        set_req(2, 4'd0, 2'd2, 2'd1, 1'b0);
        req_valid[2] = 1'b1;
        serve(-1, 1'b1);
        chk("to_loads", g_load_cnt, 1);
        chk("to_distance", g_rsp_cyc - g_load_cyc, TO);
        chk("to_err", {31'd0, g_err}, 32'd1);
        chk("to_data", {30'd0, g_data}, 32'd0);
        chk("to_decouple", {30'd0, g_dec_at_rsp, g_lv_at_rsp}, 32'h2);
        req_valid[2] = 1'b1;
        serve(2, 1'b1);
        chk("to_reload", g_load_cnt, 1);
        chk("to_reload_id", {28'd0, g_load_id}, 32'd0);
        chk("to_reload_data", {29'd0, g_err, g_data}, 32'd3);

        // ---- asynchronous reset during LOAD, stray done while idle ----
        set_req(1, 4'd6, 2'd2, 2'd3, 1'b0);
        req_valid[1] = 1'b1;
        found = 0;
        for (int w = 0; w < 20 && !found; w++) begin
            @(negedge clk_in);
            if (rm_load_req) found = 1;
        end
        chk("mid_load_reached", {31'd0, found}, 32'd1);
        @(posedge clk_in); #1;
        req_valid = '0;
        rst_in    = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rm_load_done = 1'b1;
        @(negedge clk_in);
        chk("stray_done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk_in); #1;
        rm_load_done = 1'b0;
        @(negedge clk_in);
        chk("stray_done_ignored", {26'd0, loaded_valid, loaded_id, rp_decouple}, 32'd1);
        @(posedge clk_in); #1;
        req_valid[1] = 1'b1;
        serve(1, 1'b1);
        chk("post_rst_reload", g_load_cnt, 1);
        chk("post_rst_id", {28'd0, g_load_id}, 32'd6);
        chk("post_rst_data", {30'd0, g_data}, 32'd2);
        chk("post_rst_latency", g_rsp_cyc - g_acc, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
